// File: rtl/lerp_if.sv
// Request/result bundle between the bracket-search FSM and the interpolation engine.
interface lerp_if;
  logic        start;
  logic [13:0] x_search;
  logic [15:0] x0;
  logic [15:0] y0;
  logic [15:0] x1;
  logic [15:0] y1;
  logic        busy;
  logic        done;
  logic [13:0] y_out;
  logic        clamped;
  logic        err;

  modport master (
    output start, x_search, x0, y0, x1, y1,
    input  busy, done, y_out, clamped, err
  );

  modport slave (
    input  start, x_search, x0, y0, x1, y1,
    output busy, done, y_out, clamped, err
  );
endinterface

// File: rtl/lerp_engine.sv
// Sequential linear interpolation y = y0 + (x-x0)*(y1-y0)/(x1-x0) with a bit-serial restoring divider.
// Define LERP_ROUND_EN to round the quotient half away from zero instead of truncating.
module lerp_engine #(
  parameter int Y_MAX = 9999
) (
  input  logic CLK100MHZ,
  input  logic reset_n,
  lerp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state, state_nxt;
  logic [13:0] xs_r;
  logic [15:0] x0_r, y0_r, x1_r, y1_r;
  logic        degen_r, clamp_r, neg_r;
  logic [15:0] d_r;
  logic [31:0] dq_r;
  logic [15:0] rem_r;
  logic [5:0]  cnt_r;

  // Returns {clamp, value} for a signed sum limited to 0..Y_MAX.
  function automatic logic [14:0] sat_y(input logic signed [33:0] s);
    if (s < 34'sd0)
      sat_y = {1'b1, 14'd0};
    else if (s > $signed(34'(Y_MAX)))
      sat_y = {1'b1, 14'(Y_MAX)};
    else
      sat_y = {1'b0, s[13:0]};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.x1 <= bus.x0) ? FIX : MUL;
      MUL:     state_nxt = DIV;
      DIV:     if (cnt_r == 6'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MUL: clamp abscissa, form |dx*dy| and the divisor
  logic [15:0] xs_ext, xc, dx, dy_abs, d_w;
  logic        clamp_x, neg_w;
  logic [31:0] prod, mag;

  always_comb begin
    xs_ext  = {2'b00, xs_r};
    xc      = xs_ext;
    clamp_x = 1'b0;
    if (xs_ext < x0_r) begin
      xc      = x0_r;
      clamp_x = 1'b1;
    end else if (xs_ext > x1_r) begin
      xc      = x1_r;
      clamp_x = 1'b1;
    end
    dx     = xc - x0_r;
    d_w    = x1_r - x0_r;
    neg_w  = (y1_r < y0_r);
    dy_abs = neg_w ? (y0_r - y1_r) : (y1_r - y0_r);
    prod   = 32'(dx) * 32'(dy_abs);
`ifdef LERP_ROUND_EN
    mag    = prod + 32'(d_w[15:1]);
`else
    mag    = prod;
`endif
  end

  // DIV: one restoring step, quotient bits shift into the dividend register
  logic [16:0] rem_sh;
  logic        q_bit;
  logic [15:0] rem_nxt;

  always_comb begin
    rem_sh  = {rem_r, dq_r[31]};
    q_bit   = (rem_sh >= {1'b0, d_r});
    rem_nxt = q_bit ? 16'(rem_sh - {1'b0, d_r}) : rem_sh[15:0];
  end

  // FIX: apply sign, add base ordinate, saturate
  logic signed [33:0] y0_s, q_s, s_s;
  logic        [14:0] fix_res;

  always_comb begin
    y0_s    = $signed({18'd0, y0_r});
    q_s     = neg_r ? -$signed({2'b00, dq_r}) : $signed({2'b00, dq_r});
    s_s     = y0_s + q_s;
    fix_res = degen_r ? sat_y(y0_s) : sat_y(s_s);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      state       <= IDLE;
      xs_r        <= '0;
      x0_r        <= '0;
      y0_r        <= '0;
      x1_r        <= '0;
      y1_r        <= '0;
      degen_r     <= 1'b0;
      clamp_r     <= 1'b0;
      neg_r       <= 1'b0;
      d_r         <= '0;
      dq_r        <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.y_out   <= '0;
      bus.clamped <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          xs_r     <= bus.x_search;
          x0_r     <= bus.x0;
          y0_r     <= bus.y0;
          x1_r     <= bus.x1;
          y1_r     <= bus.y1;
          degen_r  <= (bus.x1 <= bus.x0);
          clamp_r  <= 1'b0;
          bus.busy <= 1'b1;
        end
        MUL: begin
          d_r     <= d_w;
          dq_r    <= mag;
          rem_r   <= '0;
          cnt_r   <= '0;
          neg_r   <= neg_w;
          clamp_r <= clamp_x;
        end
        DIV: begin
          rem_r <= rem_nxt;
          dq_r  <= {dq_r[30:0], q_bit};
          cnt_r <= cnt_r + 6'd1;
        end
        FIX: begin
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          bus.y_out   <= fix_res[13:0];
          bus.clamped <= clamp_r | fix_res[14];
          bus.err     <= degen_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lerp_engine.sv
// Directed self-checking bench for lerp_engine: latency, slopes, rounding, saturation, degenerate and control cases.
module tb_lerp_engine;

  logic CLK100MHZ = 1'b0;
  logic reset_n;
  always #5 CLK100MHZ = ~CLK100MHZ;

  lerp_if bus();

  lerp_engine #(.Y_MAX(9999)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Drive one request; returns at the falling edge after the accepting edge k.
  task automatic launch(input logic [13:0] x, input logic [15:0] a0, b0, a1, b1);
    @(negedge CLK100MHZ);
    bus.x_search = x;
    bus.x0 = a0; bus.y0 = b0; bus.x1 = a1; bus.y1 = b1;
    bus.start = 1'b1;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    bus.start = 1'b0;
    bus.x_search = 14'd9999;
    bus.x0 = 16'd7; bus.y0 = 16'd4444; bus.x1 = 16'd3; bus.y1 = 16'd1;
  endtask

  // Waits for done (bounded); lat = cycles after edge k, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Runs a request and captures result, busy at done, and done one cycle later.
  task automatic do_op(input logic [13:0] x, input logic [15:0] a0, b0, a1, b1,
                       output int lat, output logic [13:0] y, output logic c, e, b_at, d_nxt);
    launch(x, a0, b0, a1, b1);
    wait_done(lat);
    y = bus.y_out; c = bus.clamped; e = bus.err; b_at = bus.busy;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    d_nxt = bus.done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    n_cmp++;
    if ({bus.busy, bus.done, bus.clamped, bus.err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.clamped, bus.err});
    end
    n_cmp++;
    if (bus.y_out !== 14'd0) begin
      n_bad++; $display("FAIL reset_y got %0d want 0", bus.y_out);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [13:0] y; logic c, e, b, d;
    do_op(14'd50, 16'd0, 16'd0, 16'd100, 16'd1000, lat, y, c, e, b, d);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL basic_latency got %0d want 34", lat); end
    n_cmp++; if (y !== 14'd500) begin n_bad++; $display("FAIL basic_y got %0d want 500", y); end
    n_cmp++; if ({c, e} !== 2'b00) begin n_bad++; $display("FAIL basic_flags got %b want 00", {c, e}); end
    n_cmp++; if (b !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", b); end
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", d); end
    n_cmp++; if (bus.y_out !== 14'd500) begin n_bad++; $display("FAIL basic_y_hold got %0d want 500", bus.y_out); end
  endtask

  task automatic test_negative_slope();
    int lat; logic [13:0] y; logic c, e, b, d;
    do_op(14'd15, 16'd10, 16'd9000, 16'd20, 16'd1000, lat, y, c, e, b, d);
    n_cmp++; if (y !== 14'd5000) begin n_bad++; $display("FAIL neg_y got %0d want 5000", y); end
    n_cmp++; if (c !== 1'b0) begin n_bad++; $display("FAIL neg_clamp got %b want 0", c); end
    do_op(14'd9, 16'd10, 16'd9000, 16'd20, 16'd1000, lat, y, c, e, b, d);
    n_cmp++; if (y !== 14'd9000) begin n_bad++; $display("FAIL below_y got %0d want 9000", y); end
    n_cmp++; if ({c, e} !== 2'b10) begin n_bad++; $display("FAIL below_flags got %b want 10", {c, e}); end
    do_op(14'd30, 16'd10, 16'd9000, 16'd20, 16'd1000, lat, y, c, e, b, d);
    n_cmp++; if (y !== 14'd1000) begin n_bad++; $display("FAIL above_y got %0d want 1000", y); end
    n_cmp++; if (c !== 1'b1) begin n_bad++; $display("FAIL above_clamp got %b want 1", c); end
  endtask

  task automatic test_rounding();
    int lat; logic [13:0] y; logic c, e, b, d;
    logic [13:0] exp_up, exp_dn;
`ifdef LERP_ROUND_EN
    exp_up = 14'd1; exp_dn = 14'd0;
`else
    exp_up = 14'd0; exp_dn = 14'd1;
`endif
    do_op(14'd2, 16'd0, 16'd0, 16'd3, 16'd1, lat, y, c, e, b, d);
    n_cmp++; if (y !== exp_up) begin n_bad++; $display("FAIL round_pos got %0d want %0d", y, exp_up); end
    do_op(14'd2, 16'd0, 16'd1, 16'd3, 16'd0, lat, y, c, e, b, d);
    n_cmp++; if (y !== exp_dn) begin n_bad++; $display("FAIL round_neg got %0d want %0d", y, exp_dn); end
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL round_latency got %0d want 34", lat); end
  endtask

  task automatic test_saturation();
    int lat; logic [13:0] y; logic c, e, b, d;
    do_op(14'd10, 16'd0, 16'd9000, 16'd10, 16'd20000, lat, y, c, e, b, d);
    n_cmp++; if (y !== 14'd9999) begin n_bad++; $display("FAIL sat_y got %0d want 9999", y); end
    n_cmp++; if ({c, e} !== 2'b10) begin n_bad++; $display("FAIL sat_flags got %b want 10", {c, e}); end
  endtask

  task automatic test_degenerate();
    int lat; logic [13:0] y; logic c, e, b, d;
    do_op(14'd5, 16'd5, 16'd1234, 16'd5, 16'd77, lat, y, c, e, b, d);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL degen_latency got %0d want 1", lat); end
    n_cmp++; if (y !== 14'd1234) begin n_bad++; $display("FAIL degen_y got %0d want 1234", y); end
    n_cmp++; if ({c, e} !== 2'b01) begin n_bad++; $display("FAIL degen_flags got %b want 01", {c, e}); end
    do_op(14'd5, 16'd20, 16'd12000, 16'd10, 16'd0, lat, y, c, e, b, d);
    n_cmp++; if (y !== 14'd9999) begin n_bad++; $display("FAIL degen_sat_y got %0d want 9999", y); end
    n_cmp++; if ({c, e} !== 2'b11) begin n_bad++; $display("FAIL degen_sat_flags got %b want 11", {c, e}); end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int first = -1;
    launch(14'd50, 16'd0, 16'd0, 16'd100, 16'd1000);
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) first = n;
      end
      if (n == 4) begin
        bus.x_search = 14'd5; bus.x0 = 16'd5; bus.y0 = 16'd321; bus.x1 = 16'd5; bus.y1 = 16'd0;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ignore_count got %0d want 1", dones); end
    n_cmp++; if (first !== 34) begin n_bad++; $display("FAIL ignore_latency got %0d want 34", first); end
    n_cmp++; if ({bus.y_out, bus.err} !== {14'd500, 1'b0}) begin
      n_bad++; $display("FAIL ignore_result got y=%0d err=%b want y=500 err=0", bus.y_out, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(14'd15, 16'd10, 16'd9000, 16'd20, 16'd1000);
    wait_done(lat);
    bus.x_search = 14'd50; bus.x0 = 16'd0; bus.y0 = 16'd0; bus.x1 = 16'd100; bus.y1 = 16'd1000;
    bus.start = 1'b1;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    bus.start = 1'b0;
    wait_done(lat);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency got %0d want 34", lat); end
    n_cmp++; if (bus.y_out !== 14'd500) begin n_bad++; $display("FAIL b2b_y got %0d want 500", bus.y_out); end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int lat; logic [13:0] y; logic c, e, b, d;
    launch(14'd10, 16'd0, 16'd9000, 16'd10, 16'd20000);
    for (int n = 1; n <= 19; n++) begin
      @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      if (bus.done === 1'b1) dones++;
    end
    reset_n = 1'b0;
    @(posedge CLK100MHZ);
    @(negedge CLK100MHZ);
    n_cmp++; if ({bus.busy, bus.done, bus.clamped, bus.err} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_flags got %b want 0000", {bus.busy, bus.done, bus.clamped, bus.err});
    end
    n_cmp++; if (bus.y_out !== 14'd0) begin n_bad++; $display("FAIL abort_y got %0d want 0", bus.y_out); end
    reset_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      if (bus.done === 1'b1) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
    do_op(14'd50, 16'd0, 16'd0, 16'd100, 16'd1000, lat, y, c, e, b, d);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL post_abort_latency got %0d want 34", lat); end
    n_cmp++; if (y !== 14'd500) begin n_bad++; $display("FAIL post_abort_y got %0d want 500", y); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x_search = '0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    reset_n = 1'b0;
    test_reset();
    test_basic();
    test_negative_slope();
    test_rounding();
    test_saturation();
    test_degenerate();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
